// File: rtl/reg_file.sv
// 32 x 32 MIPS register file: two combinational read ports, one write-back port, $0 hard-wired to zero.
// Optional feature: define REG_BYPASS_EN to forward write-back data to a matching read port before the edge.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] REG_address1,
    input  logic [ADDR_WIDTH-1:0] REG_address2,
    input  logic [ADDR_WIDTH-1:0] REG_address_wb,
    input  logic                  regwrite,
    input  logic [DATA_WIDTH-1:0] data_wb,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic [DATA_WIDTH-1:0] data_out_2
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic                             wr_en;
    logic [DATA_WIDTH-1:0]            rd1, rd2;

    // Address 0 is excluded here, so regs_q[0] stays zero from reset onward.
    assign wr_en = regwrite && !reset && (REG_address_wb != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en)
            regs_d[REG_address_wb] = data_wb;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            regs_q <= '0;
        else
            regs_q <= regs_d;
    end

    always_comb begin
        rd1 = (REG_address1 == '0) ? '0 : regs_q[REG_address1];
        rd2 = (REG_address2 == '0) ? '0 : regs_q[REG_address2];
    end

`ifdef REG_BYPASS_EN
    // wr_en already rules out address 0 and reset, so $0 still reads zero.
    always_comb begin
        data_out_1 = (wr_en && (REG_address_wb == REG_address1)) ? data_wb : rd1;
        data_out_2 = (wr_en && (REG_address_wb == REG_address2)) ? data_wb : rd2;
    end
`else
    always_comb begin
        data_out_1 = rd1;
        data_out_2 = rd2;
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: table-driven read sweep plus hand-written reset/r0/write-disable/same-address/dual-port sequences.
// Same-address expectations track REG_BYPASS_EN so the bench suits either build.
module tb_reg_file;
    logic        clk;
    logic        reset;
    logic [4:0]  REG_address1;
    logic [4:0]  REG_address2;
    logic [4:0]  REG_address_wb;
    logic        regwrite;
    logic [31:0] data_wb;
    logic [31:0] data_out_1;
    logic [31:0] data_out_2;

    int n_cmp = 0;
    int n_err = 0;

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .REG_address1   (REG_address1),
        .REG_address2   (REG_address2),
        .REG_address_wb (REG_address_wb),
        .regwrite       (regwrite),
        .data_wb        (data_wb),
        .data_out_1     (data_out_1),
        .data_out_2     (data_out_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    logic [31:0] wv [0:15];
    vec_t        tbl [0:7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        wv[0]  = 32'h00000000; wv[1]  = 32'hDEADBEEF; wv[2]  = 32'hCAFEBABE; wv[3]  = 32'h12345678;
        wv[4]  = 32'h87654321; wv[5]  = 32'hABCDEF01; wv[6]  = 32'h13579BDF; wv[7]  = 32'h00110011;
        wv[8]  = 32'hF0F0F0F0; wv[9]  = 32'h0F0F0F0F; wv[10] = 32'h55AA55AA; wv[11] = 32'hAA55AA55;
        wv[12] = 32'h11223344; wv[13] = 32'h55667788; wv[14] = 32'h99AABBCC; wv[15] = 32'h9ABC9ABC;
        for (int k = 0; k < 8; k++) begin
            tbl[k].a1 = 5'(2 * k + 1);
            tbl[k].a2 = (k == 7) ? 5'd0 : 5'(2 * k + 2);
            tbl[k].e1 = wv[2 * k + 1];
            tbl[k].e2 = (k == 7) ? 32'h0 : wv[2 * k + 2];
        end

        // Reset state
        reset = 1'b1; regwrite = 1'b0; REG_address_wb = 5'd0; data_wb = 32'h0;
        REG_address1 = 5'd1; REG_address2 = 5'd2;
        #1;
        check("reset_rd1", data_out_1, 32'h0);
        check("reset_rd2", data_out_2, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Write sweep r1..r15 on successive edges
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            regwrite = 1'b1; REG_address_wb = 5'(i); data_wb = wv[i];
        end
        @(negedge clk);
        regwrite = 1'b0;

        // Table-driven pair reads
        for (int k = 0; k < 8; k++) begin
            REG_address1 = tbl[k].a1; REG_address2 = tbl[k].a2;
            #1;
            check($sformatf("sweep_rd1_r%0d", tbl[k].a1), data_out_1, tbl[k].e1);
            check($sformatf("sweep_rd2_r%0d", tbl[k].a2), data_out_2, tbl[k].e2);
        end

        // r0 protection, checked before and after the edge
        @(negedge clk);
        regwrite = 1'b1; REG_address_wb = 5'd0; data_wb = 32'hFFFFFFFF;
        REG_address1 = 5'd0; REG_address2 = 5'd0;
        #1;
        check("r0_pre_rd1", data_out_1, 32'h0);
        check("r0_pre_rd2", data_out_2, 32'h0);
        after_edge();
        regwrite = 1'b0;
        #1;
        check("r0_post_rd1", data_out_1, 32'h0);
        check("r0_post_rd2", data_out_2, 32'h0);

        // Write disable over 3 edges
        @(negedge clk);
        regwrite = 1'b0; REG_address_wb = 5'd5; data_wb = 32'h11111111;
        REG_address1 = 5'd5; REG_address2 = 5'd15;
        repeat (3) after_edge();
        check("wdis_r5", data_out_1, 32'hABCDEF01);
        check("wdis_r15", data_out_2, 32'h9ABC9ABC);

        // Same-address read during write
        @(negedge clk);
        REG_address1 = 5'd7; REG_address2 = 5'd7;
        regwrite = 1'b1; REG_address_wb = 5'd7; data_wb = 32'h0BADF00D;
        #1;
`ifdef REG_BYPASS_EN
        check("same_pre_rd1", data_out_1, 32'h0BADF00D);
        check("same_pre_rd2", data_out_2, 32'h0BADF00D);
`else
        check("same_pre_rd1", data_out_1, 32'h00110011);
        check("same_pre_rd2", data_out_2, 32'h00110011);
`endif
        after_edge();
        regwrite = 1'b0;
        #1;
        check("same_post_rd1", data_out_1, 32'h0BADF00D);
        check("same_post_rd2", data_out_2, 32'h0BADF00D);

        // Dual port on r31
        @(negedge clk);
        regwrite = 1'b1; REG_address_wb = 5'd31; data_wb = 32'hA5A5A5A5;
        after_edge();
        regwrite = 1'b0;
        REG_address1 = 5'd31; REG_address2 = 5'd31;
        #1;
        check("dual_rd1", data_out_1, 32'hA5A5A5A5);
        check("dual_rd2", data_out_2, 32'hA5A5A5A5);

        // Mid-cycle reset clears without a clock edge
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 1; i < 16; i++) begin
            REG_address1 = 5'(i); REG_address2 = 5'(16 + i);
            #1;
            check($sformatf("midrst_r%0d", i), data_out_1, 32'h0);
            check($sformatf("midrst_r%0d", 16 + i), data_out_2, 32'h0);
        end

        // Write attempted while reset is held is ignored
        regwrite = 1'b1; REG_address_wb = 5'd3; data_wb = 32'h77777777;
        REG_address1 = 5'd3; REG_address2 = 5'd31;
        #1;
        check("rsthold_pre_r3", data_out_1, 32'h0);
        after_edge();
        check("rsthold_post_r3", data_out_1, 32'h0);
        check("rsthold_r31", data_out_2, 32'h0);
        @(negedge clk);
        regwrite = 1'b0; reset = 1'b0;
        #1;
        check("rstrel_r3", data_out_1, 32'h0);

        // Normal write after reset release
        @(negedge clk);
        regwrite = 1'b1; REG_address_wb = 5'd3; data_wb = 32'h3C3C3C3C;
        after_edge();
        regwrite = 1'b0;
        #1;
        check("postrst_wr_r3", data_out_1, 32'h3C3C3C3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
